// File: rtl/a5_pkg.sv
// Shared constants, FSM state type and majority helper for the A5/1-style cipher core.
// The tap indices are shared with the X/Y/Z LFSR modules.
package a5_pkg;

    localparam int unsigned KEY_W   = 64;
    localparam int unsigned FRAME_W = 22;
    localparam int unsigned WARMUP  = 100;
    localparam int unsigned CNT_W   = 7;

    localparam int unsigned X_CLK_TAP = 8;
    localparam int unsigned Y_CLK_TAP = 10;
    localparam int unsigned Z_CLK_TAP = 10;

    localparam logic [CNT_W-1:0] KeyLast    = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] FrameLast  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WarmupLast = CNT_W'(WARMUP - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StLoadKey,
        StLoadFrame,
        StWarmup,
        StReady
    } state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/a5_key_loader_if.sv
// LFSR load interface: the loader (master) drives clear/shift/trigger towards the X/Y/Z
// registers and receives start, key, frame and the three clocking taps.
interface a5_key_loader_if;
    import a5_pkg::*;

    logic               start;
    logic [KEY_W-1:0]   key;
    logic [FRAME_W-1:0] frame;
    logic               x_clk_bit;
    logic               y_clk_bit;
    logic               z_clk_bit;
    logic               lfsr_clear;
    logic               shift_bit;
    logic               trigger_x;
    logic               trigger_y;
    logic               trigger_z;
    logic               busy;
    logic               ready;
    logic               done;

    modport master (
        input  start, key, frame, x_clk_bit, y_clk_bit, z_clk_bit,
        output lfsr_clear, shift_bit, trigger_x, trigger_y, trigger_z, busy, ready, done
    );

    modport slave (
        output start, key, frame, x_clk_bit, y_clk_bit, z_clk_bit,
        input  lfsr_clear, shift_bit, trigger_x, trigger_y, trigger_z, busy, ready, done
    );

endinterface

// File: rtl/a5_majority.sv
// Majority clocking rule: a register steps when its clocking tap agrees with the majority.
// Also used by the encrypt datapath for run-time clocking.
module a5_majority
    import a5_pkg::*;
(
    input  logic x_clk_bit_i,
    input  logic y_clk_bit_i,
    input  logic z_clk_bit_i,
    output logic trigger_x_o,
    output logic trigger_y_o,
    output logic trigger_z_o
);

    logic m;

    assign m           = maj3(x_clk_bit_i, y_clk_bit_i, z_clk_bit_i);
    assign trigger_x_o = ~(x_clk_bit_i ^ m);
    assign trigger_y_o = ~(y_clk_bit_i ^ m);
    assign trigger_z_o = ~(z_clk_bit_i ^ m);

endmodule

// File: rtl/a5_key_loader.sv
// Initialisation sequencer: clear, serial key/frame load into X/Y/Z, majority-clocked warm-up,
// then hand over LFSR clocking by raising ready.
module a5_key_loader
    import a5_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    a5_key_loader_if.master  lif
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [KEY_W-1:0]   key_sr_q;
    logic [FRAME_W-1:0] frame_sr_q;
    logic               clear_q;
    logic               busy_q;
    logic               ready_q;
    logic               done_q;

    logic maj_x, maj_y, maj_z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            key_sr_q   <= '0;
            frame_sr_q <= '0;
            clear_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                StIdle, StReady: begin
                    if (lif.start) begin
                        key_sr_q   <= lif.key;
                        frame_sr_q <= lif.frame;
                        cnt_q      <= '0;
                        clear_q    <= 1'b1;
                        busy_q     <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= StClear;
                    end
                end
                StClear: begin
                    cnt_q   <= '0;
                    state_q <= StLoadKey;
                end
                StLoadKey: begin
                    key_sr_q <= key_sr_q >> 1;
                    if (cnt_q == KeyLast) begin
                        cnt_q   <= '0;
                        state_q <= StLoadFrame;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StLoadFrame: begin
                    frame_sr_q <= frame_sr_q >> 1;
                    if (cnt_q == FrameLast) begin
                        cnt_q   <= '0;
                        state_q <= StWarmup;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWarmup: begin
                    if (cnt_q == WarmupLast) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= StReady;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    a5_majority u_majority (
        .x_clk_bit_i (lif.x_clk_bit),
        .y_clk_bit_i (lif.y_clk_bit),
        .z_clk_bit_i (lif.z_clk_bit),
        .trigger_x_o (maj_x),
        .trigger_y_o (maj_y),
        .trigger_z_o (maj_z)
    );

    // Shift registers present their LSB; triggers only go combinational during warm-up.
    always_comb begin
        lif.shift_bit = 1'b0;
        lif.trigger_x = 1'b0;
        lif.trigger_y = 1'b0;
        lif.trigger_z = 1'b0;
        case (state_q)
            StLoadKey: begin
                lif.shift_bit = key_sr_q[0];
                lif.trigger_x = 1'b1;
                lif.trigger_y = 1'b1;
                lif.trigger_z = 1'b1;
            end
            StLoadFrame: begin
                lif.shift_bit = frame_sr_q[0];
                lif.trigger_x = 1'b1;
                lif.trigger_y = 1'b1;
                lif.trigger_z = 1'b1;
            end
            StWarmup: begin
                lif.trigger_x = maj_x;
                lif.trigger_y = maj_y;
                lif.trigger_z = maj_z;
            end
            default: ;
        endcase
    end

    assign lif.lfsr_clear = clear_q;
    assign lif.busy       = busy_q;
    assign lif.ready      = ready_q;
    assign lif.done       = done_q;

endmodule

// File: tb/tb_a5_key_loader.sv
// Directed bench for a5_key_loader: cycle-by-cycle check of the 188-cycle init sequence,
// warm-up majority triggers, start filtering while busy, restart from READY and reset abort.
module tb_a5_key_loader;
    import a5_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    a5_key_loader_if lif ();

    a5_key_loader dut (
        .clk   (clk),
        .reset (reset),
        .lif   (lif)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs();
        return int'({lif.lfsr_clear, lif.shift_bit, lif.trigger_x, lif.trigger_y,
                     lif.trigger_z, lif.busy, lif.ready, lif.done});
    endfunction

    // Tap patterns cycle with period 4; cycle 88 (first warm-up step) uses pattern 0.
    function automatic logic [2:0] tap_pat(input int c);
        case (c % 4)
            0:       return 3'b110;
            1:       return 3'b010;
            2:       return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [2:0] warm_trig(input logic [2:0] t);
        case (t)
            3'b110:  return 3'b110;
            3'b010:  return 3'b101;
            3'b111:  return 3'b111;
            default: return 3'b111;
        endcase
    endfunction

    task automatic run_init(input logic [63:0] k, input logic [21:0] f, input int pulse_c,
                            input int abort_c, input int exp_ones, input string tag);
        int e_clr = 0, e_busy = 0, e_rdy = 0, e_done = 0, e_sb = 0, e_trg = 0;
        int ones = 0, tx = 0, dones = 0, last;
        logic [2:0] taps, exp_t, got_t;
        logic exp_sb;
        lif.key   = k;
        lif.frame = f;
        lif.start = 1'b1;
        @(posedge clk); #1;
        lif.start = 1'b0;
        lif.key   = ~k;
        lif.frame = ~f;
        last = (abort_c > 0) ? abort_c : 189;
        for (int c = 1; c <= last; c++) begin
            taps = tap_pat(c);
            {lif.x_clk_bit, lif.y_clk_bit, lif.z_clk_bit} = taps;
            lif.start = (c == pulse_c);
            if (c == abort_c) reset = 1'b1;
            #1;
            exp_sb = 1'b0;
            if (c >= 2 && c <= 65) exp_sb = k[c-2];
            else if (c >= 66 && c <= 87) exp_sb = f[c-66];
            if (c >= 2 && c <= 87) exp_t = 3'b111;
            else if (c >= 88 && c <= 187) exp_t = warm_trig(taps);
            else exp_t = 3'b000;
            got_t = {lif.trigger_x, lif.trigger_y, lif.trigger_z};
            if (lif.lfsr_clear !== (c == 1)) e_clr++;
            if (lif.busy !== (c >= 1 && c <= 187)) e_busy++;
            if (lif.ready !== (c >= 188)) e_rdy++;
            if (lif.done !== (c == 188)) e_done++;
            if (lif.shift_bit !== exp_sb) e_sb++;
            if (got_t !== exp_t) e_trg++;
            if (lif.shift_bit === 1'b1) ones++;
            if (c <= 87 && lif.trigger_x === 1'b1) tx++;
            if (lif.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        lif.start = 1'b0;
        check_val({tag, "_clear"}, e_clr, 0);
        check_val({tag, "_busy"}, e_busy, 0);
        check_val({tag, "_ready"}, e_rdy, 0);
        check_val({tag, "_done"}, e_done, 0);
        check_val({tag, "_shift"}, e_sb, 0);
        check_val({tag, "_trig"}, e_trg, 0);
        if (abort_c > 0) begin
            check_val({tag, "_rst_outs"}, outs(), 0);
            reset = 1'b0;
        end else begin
            check_val({tag, "_ones"}, ones, exp_ones);
            check_val({tag, "_trig_x_load"}, tx, 86);
            check_val({tag, "_done_cnt"}, dones, 1);
        end
    endtask

    initial begin
        reset         = 1'b1;
        lif.start     = 1'b1;
        lif.key       = 64'hFFFF_FFFF_FFFF_FFFF;
        lif.frame     = 22'h3F_FFFF;
        lif.x_clk_bit = 1'b0;
        lif.y_clk_bit = 1'b0;
        lif.z_clk_bit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("reset_outs", outs(), 0);
        end
        reset     = 1'b0;
        lif.start = 1'b0;
        @(posedge clk); #1;
        check_val("idle_outs", outs(), 0);

        run_init(64'h1, 22'h0, -1, -1, 1, "key1");
        // Starts from READY; the start at cycle 100 must be ignored.
        run_init(64'h0, 22'h20_0001, 100, -1, 2, "frame");
        run_init(64'hA5A5_0F0F_1234_8001, 22'h1_5A3C, -1, 50, -1, "abort");
        check_val("post_abort_idle", outs(), 0);
        run_init(64'hDEAD_BEEF_0000_0003, 22'h3, -1, -1, 28, "newkey");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
